// File: rtl/uart_led_cmd.sv
// uart_led_cmd: ASCII command parser that drives 4 LEDs in static, blink or rotate mode.
// Optional macro UART_LED_CMD_ACK_EN adds ack_data/ack_vld for host acknowledgement.
module uart_led_cmd #(
  parameter int UNIT_CYCLES    = 7_812_500,
  parameter int TIMEOUT_CYCLES = 125_000_000
) (
  input  logic       clk_rx,
  input  logic       rst_n_clk_rx,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  input  logic       frm_err,
  input  logic       btn_clk_rx,
  output logic [3:0] led_o,
  output logic       cmd_err
`ifdef UART_LED_CMD_ACK_EN
  ,
  output logic [7:0] ack_data,
  output logic       ack_vld
`endif
);

  localparam int PW = $clog2(UNIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_EXEC} state_t;
  typedef enum logic [1:0] {MODE_STATIC, MODE_BLINK, MODE_ROTATE} mode_t;
  typedef enum logic [1:0] {OP_L, OP_B, OP_R, OP_C} op_t;

  state_t        state, state_next;
  op_t           op, op_next, byte_op;
  logic [3:0]    arg, arg_next, hex_val;
  logic [TW-1:0] timer, timer_next;
  logic          err_next, is_op_arg, is_op_c, is_hex;

  mode_t         mode;
  logic [3:0]    pat, rate, tick, led_next;
  logic [PW-1:0] presc;
  logic          phase, unit_pulse, step;

  always_comb begin
    byte_op   = OP_L;
    is_op_arg = 1'b0;
    is_op_c   = 1'b0;
    is_hex    = 1'b0;
    hex_val   = 4'h0;
    case (rx_data)
      8'h4C, 8'h6C: begin byte_op = OP_L; is_op_arg = 1'b1; end
      8'h42, 8'h62: begin byte_op = OP_B; is_op_arg = 1'b1; end
      8'h52, 8'h72: begin byte_op = OP_R; is_op_arg = 1'b1; end
      8'h43, 8'h63: begin byte_op = OP_C; is_op_c   = 1'b1; end
      default: ;
    endcase
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex  = 1'b1;
      hex_val = rx_data[3:0] + 4'd9;
    end
  end

  // A framing error always wins; in ARG a byte beats a same-cycle timeout.
  always_comb begin
    state_next = state;
    op_next    = op;
    arg_next   = arg;
    timer_next = timer;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_next = '0;
        if (!frm_err && rx_data_rdy) begin
          if (is_op_arg) begin
            op_next    = byte_op;
            state_next = ST_ARG;
          end else if (is_op_c) begin
            op_next    = OP_C;
            arg_next   = 4'h0;
            state_next = ST_EXEC;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_ARG: begin
        if (frm_err) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end else if (rx_data_rdy) begin
          if (is_hex) begin
            arg_next   = hex_val;
            state_next = ST_EXEC;
          end else begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
          end
        end else if (timer == TIMER_LAST) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        err_next   = rx_data_rdy && !frm_err;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_rx or negedge rst_n_clk_rx) begin
    if (!rst_n_clk_rx) begin
      state   <= ST_IDLE;
      op      <= OP_L;
      arg     <= 4'h0;
      timer   <= '0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_next;
      op      <= op_next;
      arg     <= arg_next;
      timer   <= timer_next;
      cmd_err <= err_next;
    end
  end

  always_comb begin
    unit_pulse = (presc == PRESC_LAST);
    step       = unit_pulse && (tick == rate);
    case (mode)
      MODE_BLINK: led_next = phase ? pat : 4'h0;
      default:    led_next = pat;
    endcase
  end

  // A command load restarts the animation timebase; the button freezes it otherwise.
  always_ff @(posedge clk_rx or negedge rst_n_clk_rx) begin
    if (!rst_n_clk_rx) begin
      mode  <= MODE_STATIC;
      pat   <= 4'h0;
      rate  <= 4'h0;
      presc <= '0;
      tick  <= 4'h0;
      phase <= 1'b1;
    end else if (state == ST_EXEC) begin
      presc <= '0;
      tick  <= 4'h0;
      phase <= 1'b1;
      case (op)
        OP_L: begin pat <= arg; mode <= MODE_STATIC; end
        OP_B: begin rate <= arg; mode <= MODE_BLINK; end
        OP_R: begin rate <= arg; mode <= MODE_ROTATE; end
        default: begin pat <= 4'h0; mode <= MODE_STATIC; end
      endcase
    end else if (!btn_clk_rx) begin
      presc <= unit_pulse ? '0 : presc + 1'b1;
      if (unit_pulse)
        tick <= (tick == rate) ? 4'h0 : tick + 4'd1;
      if (step && mode == MODE_BLINK)
        phase <= ~phase;
      if (step && mode == MODE_ROTATE)
        pat <= {pat[2:0], pat[3]};
    end
  end

  always_ff @(posedge clk_rx or negedge rst_n_clk_rx) begin
    if (!rst_n_clk_rx)
      led_o <= 4'h0;
    else if (!btn_clk_rx)
      led_o <= led_next;
  end

`ifdef UART_LED_CMD_ACK_EN
  // cmd_err and EXEC can never coincide, so '?' taking priority is only defensive.
  always_comb begin
    ack_vld  = cmd_err || (state == ST_EXEC);
    ack_data = 8'h00;
    if (cmd_err)
      ack_data = 8'h3F;
    else if (state == ST_EXEC)
      ack_data = 8'h4B;
  end
`endif

endmodule

// File: tb/tb_uart_led_cmd.sv
// tb_uart_led_cmd: randomized scoreboard bench for uart_led_cmd (default build, no ack ports).
// A reference model predicts led_o/cmd_err per cycle; a monitor pops and compares.
module tb_uart_led_cmd;

  localparam int U = 4;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_rdy = 1'b0;
  logic       frm_err = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] led_o;
  logic       cmd_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] led;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  uart_led_cmd #(.UNIT_CYCLES(U), .TIMEOUT_CYCLES(T)) dut (
    .clk_rx       (clk),
    .rst_n_clk_rx (rst_n),
    .rx_data      (rx_data),
    .rx_data_rdy  (rx_data_rdy),
    .frm_err      (frm_err),
    .btn_clk_rx   (btn),
    .led_o        (led_o),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] v, input int s);
    logic [3:0] r = v;
    for (int i = 0; i < s; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  function automatic bit hex_char(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic logic [3:0] hex_value(input logic [7:0] b);
    int v;
    if (b <= "9") v = b - "0";
    else if (b <= "F") v = b - "A" + 10;
    else v = b - "a" + 10;
    return 4'(v);
  endfunction

  // Reference model: mode 0 static, 1 blink, 2 rotate; animation derived from
  // the number of unfrozen edges since the last command load.
  int         cyc = 0;
  logic [7:0] m_pend = 8'h00;
  int         m_pend_edge = 0;
  bit         m_load = 1'b0;
  logic [7:0] m_lop = 8'h00;
  logic [3:0] m_larg = 4'h0;
  int         m_mode = 0;
  logic [3:0] m_pat = 4'h0;
  logic [3:0] m_rate = 4'h0;
  int         m_n = 0;
  logic [3:0] m_led = 4'h0;
  bit         m_err = 1'b0;

  always @(posedge clk) begin
    int         per, s;
    logic [3:0] cur_pat, out_v;
    logic [7:0] u;
    bit         err;
    cyc++;
    if (!rst_n) begin
      m_pend = 8'h00; m_load = 1'b0; m_mode = 0; m_pat = 4'h0; m_rate = 4'h0;
      m_n = 0; m_led = 4'h0; m_err = 1'b0;
    end else begin
      per     = (int'(m_rate) + 1) * U;
      s       = m_n / per;
      cur_pat = (m_mode == 2) ? rotl(m_pat, s % 4) : m_pat;
      out_v   = (m_mode == 1) ? ((s % 2 == 0) ? m_pat : 4'h0) : cur_pat;
      if (!btn) m_led = out_v;
      err = 1'b0;
      if (m_load) begin
        case (m_lop)
          "L": begin m_pat = m_larg; m_mode = 0; end
          "B": begin m_pat = cur_pat; m_rate = m_larg; m_mode = 1; end
          "R": begin m_pat = cur_pat; m_rate = m_larg; m_mode = 2; end
          default: begin m_pat = 4'h0; m_mode = 0; end
        endcase
        m_n = 0;
        m_load = 1'b0;
        if (rx_data_rdy && !frm_err) err = 1'b1;
      end else begin
        if (!btn) m_n++;
        if (frm_err) begin
          if (m_pend != 8'h00) err = 1'b1;
          m_pend = 8'h00;
        end else if (m_pend != 8'h00) begin
          if (rx_data_rdy) begin
            if (hex_char(rx_data)) begin
              m_load = 1'b1; m_lop = m_pend; m_larg = hex_value(rx_data);
            end else err = 1'b1;
            m_pend = 8'h00;
          end else if (cyc - m_pend_edge == T + 1) begin
            err = 1'b1;
            m_pend = 8'h00;
          end
        end else if (rx_data_rdy) begin
          u = (rx_data >= "a" && rx_data <= "z") ? rx_data - 8'd32 : rx_data;
          if (u == "L" || u == "B" || u == "R") begin
            m_pend = u; m_pend_edge = cyc;
          end else if (u == "C") begin
            m_load = 1'b1; m_lop = "C";
          end else err = 1'b1;
        end
      end
      m_err = err;
    end
    exp_q.push_back('{led: m_led, err: m_err});
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("led_o", {4'h0, led_o}, {4'h0, e.led});
      check_output("cmd_err", {7'h0, cmd_err}, {7'h0, e.err});
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input logic rdy, input logic ferr, input int idle);
    repeat (idle) begin
      @(negedge clk);
      rx_data_rdy = 1'b0;
      frm_err = 1'b0;
    end
    @(negedge clk);
    rx_data = b;
    rx_data_rdy = rdy;
    frm_err = ferr;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_data_rdy = 1'b0;
      frm_err = 1'b0;
    end
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    rx_data_rdy = 1'b0;
    frm_err = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output({name, "_led"}, {4'h0, led_o}, 8'h00);
    check_output({name, "_err"}, {7'h0, cmd_err}, 8'h00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [7:0] op_tab[8]   = '{"L", "B", "R", "C", "l", "b", "r", "c"};
  logic [7:0] hex_tab[10] = '{"0", "5", "9", "A", "c", "F", "f", "3", "7", "e"};

  initial begin
    int r, idle;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    apply_stimulus("L", 1, 0, 1); apply_stimulus("5", 1, 0, 1); idle_cycles(6);
    apply_stimulus("L", 1, 0, 1); apply_stimulus("A", 1, 0, 1);
    apply_stimulus("B", 1, 0, 2); apply_stimulus("1", 1, 0, 1); idle_cycles(40);
    apply_stimulus("L", 1, 0, 1); apply_stimulus("1", 1, 0, 1);
    apply_stimulus("r", 1, 0, 2); apply_stimulus("0", 1, 0, 1); idle_cycles(14);
    btn = 1'b1; idle_cycles(10); btn = 1'b0; idle_cycles(10);
    apply_stimulus("X", 1, 0, 1); apply_stimulus("L", 1, 0, 3);
    apply_stimulus("G", 1, 0, 1); idle_cycles(5);
    apply_stimulus("L", 1, 0, 1); idle_cycles(60); apply_stimulus("3", 1, 0, 0);
    apply_stimulus("L", 1, 0, 2); apply_stimulus("9", 1, 0, T);
    apply_stimulus("L", 1, 0, 2); apply_stimulus("6", 1, 0, T + 1);
    apply_stimulus("L", 1, 0, 2); apply_stimulus("4", 1, 1, 1);
    apply_stimulus("L", 1, 1, 2); idle_cycles(3);
    apply_stimulus("L", 1, 0, 2); apply_stimulus("2", 1, 0, 1);
    apply_stimulus("C", 1, 0, 0); idle_cycles(5);
    apply_stimulus("L", 1, 0, 2); idle_cycles(3); async_reset("rst_arg");
    apply_stimulus("L", 1, 0, 1); apply_stimulus("F", 1, 0, 1);
    apply_stimulus("B", 1, 0, 1); apply_stimulus("0", 1, 0, 1); idle_cycles(10);
    async_reset("rst_blink");
    apply_stimulus("L", 1, 0, 1); apply_stimulus("7", 1, 0, 1); idle_cycles(6);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) b = op_tab[$urandom_range(0, 7)];
      else if (r <= 7) b = hex_tab[$urandom_range(0, 9)];
      else b = 8'($urandom_range(0, 255));
      idle = ($urandom_range(0, 19) == 0) ? $urandom_range(T - 2, T + 4) : $urandom_range(0, 8);
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      apply_stimulus(b, 1'b1, ($urandom_range(0, 19) == 0), idle);
    end
    btn = 1'b0;
    idle_cycles(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
